// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and baud-period formula shared by the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    function automatic int baud_count(input int clk_freq_mhz, input int baudrate);
        return clk_freq_mhz * 1_000_000 / baudrate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with valid/ack handshake, framing-error pulse and sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BAUDRATE       = 9600,
    parameter int CLK_FREQ_MHZ   = 125,
    parameter int BAUDRATE_COUNT = baud_count(CLK_FREQ_MHZ, BAUDRATE),
    parameter int BAUDRATE_WIDTH = $clog2(BAUDRATE_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int BIT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [BAUDRATE_WIDTH-1:0] BAUD_LAST = BAUDRATE_WIDTH'(BAUDRATE_COUNT - 1);
    localparam logic [BAUDRATE_WIDTH-1:0] BAUD_HALF = BAUDRATE_WIDTH'(BAUDRATE_COUNT / 2 - 1);
    localparam logic [BIT_WIDTH-1:0]      BIT_LAST  = BIT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state, state_n;
    logic [BAUDRATE_WIDTH-1:0] baud_cnt, baud_n;
    logic [BIT_WIDTH-1:0]    bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_n;
    logic                    good, good_n, ferr_n;
    logic                    rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != IDLE);

    always_comb begin
        state_n = state;
        baud_n  = (state == IDLE) ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        good_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: if (!rx_s) state_n = START;
            START: if (baud_cnt == BAUD_HALF) begin
                state_n = rx_s ? IDLE : DATA;
                baud_n  = '0;
                bit_n   = '0;
            end
            // shifting in from the top leaves bit 0 at the LSB after the last data bit
            DATA: if (baud_cnt == BAUD_LAST) begin
                shift_n = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                bit_n   = bit_cnt + 1'b1;
                baud_n  = '0;
                if (bit_cnt == BIT_LAST) state_n = STOP;
            end
            STOP: if (baud_cnt == BAUD_LAST) begin
                baud_n  = '0;
                good_n  = rx_s;
                ferr_n  = !rx_s;
                state_n = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                baud_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            good      <= 1'b0;
            frame_err <= 1'b0;
            data_o    <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            good      <= good_n;
            frame_err <= ferr_n;
            // a completion beats a same-cycle ack; the ack still absorbs the old byte so no overrun
            if (good) begin
                data_o   <= shift_reg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard queue checked by a decoupled output monitor.
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] data_o;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ferr_seen = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx #(.BAUDRATE_COUNT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .data_o    (data_o),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic ov);
        exp_t e;
        e.d  = d;
        e.ov = ov;
        q.push_back(e);
    endtask

    task automatic ack(input string name);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
        check({name, "_valid_clr"}, int'(rx_valid), 0);
        check({name, "_overrun_clr"}, int'(overrun), 0);
    endtask

    // monitor: a new byte is presented when rx_valid rises or data_o changes while valid
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rx_valid && (!prev_valid || data_o != prev_data)) begin
                if (q.size() == 0) begin
                    check("unexpected_byte", int'(data_o), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("byte_data", int'(data_o), int'(e.d));
                    check("byte_overrun", int'(overrun), int'(e.ov));
                end
            end
            if (frame_err) begin
                ferr_seen++;
                if (prev_ferr) check("frame_err_width", 2, 1);
            end
            prev_valid = rx_valid;
            prev_data  = data_o;
            prev_ferr  = frame_err;
        end
    end

    initial begin
        int seen_busy;
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(data_o), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_busy", int'(rx_busy), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        check("a5_ferr", int'(frame_err), 0);
        ack("a5");

        // start glitch shorter than half a bit
        seen_busy = 0;
        rx = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1;
        end
        rx = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1;
        end
        check("glitch_busy_seen", seen_busy, 1);
        check("glitch_busy_idle", int'(rx_busy), 0);
        check("glitch_valid", int'(rx_valid), 0);

        // bad stop bit, line held low
        send_frame(8'h3C, 1'b0);
        repeat (32) @(negedge clk);
        check("break_busy", int'(rx_busy), 1);
        check("break_valid", int'(rx_valid), 0);
        check("break_ferr_count", ferr_seen, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_exit", int'(rx_busy), 0);
        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        ack("x55");

        expect_byte(8'h12, 1'b0);
        expect_byte(8'h34, 1'b1);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        check("b2b_data", int'(data_o), 8'h34);
        check("b2b_overrun", int'(overrun), 1);
        ack("b2b");

        // ack lands on the same clk that 0x81 is delivered
        expect_byte(8'h7E, 1'b0);
        send_frame(8'h7E, 1'b1);
        expect_byte(8'h81, 1'b0);
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (155) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check("same_cycle_valid", int'(rx_valid), 1);
        check("same_cycle_data", int'(data_o), 8'h81);
        check("same_cycle_overrun", int'(overrun), 0);

        // reset in data bit 4 of 0xFF
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(negedge clk);
                rst = 1'b1;
                #1;
                check("midrst_data", int'(data_o), 0);
                check("midrst_valid", int'(rx_valid), 0);
                check("midrst_busy", int'(rx_busy), 0);
                check("midrst_overrun", int'(overrun), 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        check("midrst_no_byte", int'(rx_valid), 0);
        expect_byte(8'h00, 1'b0);
        send_frame(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        check("final_ferr_count", ferr_seen, 1);
        check("final_valid", int'(rx_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 framing, LSB first. It is the receiving end of the team's UART TX and uses the same BAUDRATE and CLK_FREQ_MHZ parameters.
- Samples the asynchronous rx line in the clk domain using a bit-period counter. No derived clock.
- Delivers each received byte on a valid/ack handshake. Reports framing errors and overruns.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- BAUDRATE, 9600, line rate in bit/s.
- CLK_FREQ_MHZ, 125, clk frequency in MHz.
- BAUDRATE_COUNT, CLK_FREQ_MHZ*1_000_000/BAUDRATE (13020 at defaults), clk cycles per bit. The bench overrides it to 16.
- BAUDRATE_WIDTH, $clog2(BAUDRATE_COUNT), width of the bit-period counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; asynchronous; idles high.
- rx_ack  in  1  consumer acknowledge; clears rx_valid.
- data_o  out  DATA_WIDTH  last good byte; held stable while rx_valid=1.
- rx_valid  out  1  level; byte available in data_o.
- rx_busy  out  1  high whenever the state is not IDLE.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- overrun  out  1  sticky; a new byte completed while rx_valid=1. Cleared by rx_ack.

Behaviour:
- Reset values: data_o=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, state=IDLE. The synchronizer flops reset to 1.
- rst asserted mid-frame aborts the frame immediately. No valid or error output is produced for it.
- Input path: rx goes through a 2-flop synchronizer to rx_s. Every edge and sample decision below uses rx_s.
- baud_cnt: counts 0..BAUDRATE_COUNT-1. It is held at 0 in IDLE.
- States:
  - IDLE: on rx_s=0, go to START and clear baud_cnt.
  - START: when baud_cnt reaches BAUDRATE_COUNT/2-1 (mid start bit), sample rx_s.
    - Sample 0: go to DATA, clear baud_cnt and bit_cnt.
    - Sample 1: treat as a glitch and return to IDLE with no outputs.
  - DATA: each time baud_cnt reaches BAUDRATE_COUNT-1 (mid bit), shift rx_s into shift_reg[bit_cnt] (LSB first) and increment bit_cnt.
    - After bit DATA_WIDTH-1 is sampled, go to STOP.
  - STOP: at the next mid-bit point, sample rx_s.
    - Sample 1: the frame is good. Next cycle, data_o<=shift_reg and rx_valid<=1. Go to IDLE.
    - Sample 0: pulse frame_err for one cycle and go to BREAK. data_o and rx_valid are unchanged.
  - BREAK: wait for rx_s=1, then go to IDLE. A line held low never re-triggers a frame.
- Latency: rx_valid rises 1 clk after the stop-bit mid sample. The falling start edge at the pin reaches the FSM 2 clks later.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid and overrun on the next clk.
  - rx_ack while rx_valid=0 is ignored.
- Overrun: a good frame that completes while rx_valid=1 still updates data_o to the new byte, keeps rx_valid=1, and sets overrun.
  - Same-cycle rx_ack and completion: the completion wins. rx_valid stays 1 and overrun stays clear.
- Back-to-back frames: IDLE is re-entered at mid stop bit. A start edge right after the stop bit is therefore detected without loss.
- bit_cnt width: $clog2(DATA_WIDTH)+1. It must not wrap before the terminal compare.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/STOP/BREAK as a 3-bit localparam set;
  - the BAUDRATE_COUNT formula, shared with UART TX.
- One natural sub-module: uart_sync2, the 2-flop synchronizer with a reset value parameter.
- The rest of the design is a single FSM module.

Test Plan:
- BAUDRATE_COUNT=16; drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> data_o=0xA5, rx_valid=1 within 1 clk after the stop mid-sample, frame_err=0, overrun=0.
- rx low for 6 clks (< half bit), then high -> rx_busy pulses, returns to IDLE, rx_valid never asserts.
- Frame 0x3C with stop bit driven 0 -> frame_err one-cycle pulse, rx_valid=0, FSM stays BREAK until rx high, then next frame 0x55 received correctly.
- Two back-to-back frames 0x12, 0x34 with no rx_ack -> data_o=0x34, rx_valid=1, overrun=1; then rx_ack -> rx_valid=0, overrun=0 next clk.
- rx_ack asserted in the same cycle that frame 0x81 completes (previous 0x7E pending) -> data_o=0x81, rx_valid=1, overrun=0.
- Assert rst during data bit 4 of 0xFF -> all outputs 0 immediately; after release, frame 0x00 received correctly.
